// File: rtl/writeback_register_file.sv
// writeback_register_file: 32x32 integer register file written by WB, read by decode with same-cycle WB bypass.
// x0 is hardwired to zero; the debug port shows committed state only.
module writeback_register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] wb_data_in,
    input  logic [ADDR_WIDTH-1:0] rd_in,
    input  logic                  is_write_in,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic [DATA_WIDTH-1:0] rs1_data,
    output logic [DATA_WIDTH-1:0] rs2_data,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data,
    output logic [15:0]           write_count,
    output logic [ADDR_WIDTH-1:0] last_rd
);
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  commit;

    // Gating with reset also kills the bypass, so reads return the cleared array while reset is high.
    assign commit = is_write_in && (rd_in != '0) && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            write_count <= '0;
            last_rd     <= '0;
        end else if (commit) begin
            regs[rd_in] <= wb_data_in;
            write_count <= write_count + 16'd1;
            last_rd     <= rd_in;
        end
    end

    // Entry 0 is never written, so a stored read of x0 is already zero.
    always_comb begin
        rs1_data = (commit && rd_in == rs1_addr) ? wb_data_in : regs[rs1_addr];
        rs2_data = (commit && rd_in == rs2_addr) ? wb_data_in : regs[rs2_addr];
        dbg_data = regs[dbg_addr];
    end
endmodule

// File: tb/tb_writeback_register_file.sv
// tb_writeback_register_file: directed and randomized checks against an array-based register model.
module tb_writeback_register_file;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] wb_data_in;
    logic [4:0]  rd_in;
    logic        is_write_in;
    logic [4:0]  rs1_addr, rs2_addr, dbg_addr;
    logic [31:0] rs1_data, rs2_data, dbg_data;
    logic [15:0] write_count;
    logic [4:0]  last_rd;

    writeback_register_file dut (
        .clk(clk), .reset(reset), .wb_data_in(wb_data_in), .rd_in(rd_in),
        .is_write_in(is_write_in), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .dbg_addr(dbg_addr),
        .dbg_data(dbg_data), .write_count(write_count), .last_rd(last_rd)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [32];
    int          cnt;
    logic [4:0]  last;
    int          total = 0;
    int          fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mem[i] = 32'd0;
        cnt  = 0;
        last = 5'd0;
    endtask

    // Architectural view seen by decode: x0 is zero, an in-flight write to a nonzero index wins.
    function automatic logic [31:0] read_exp(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (is_write_in && rd_in == a) return wb_data_in;
        return mem[a];
    endfunction

    // Called at posedge+1: drive one cycle, check reads mid-cycle, commit at the edge, check counters.
    task automatic apply(input logic we, input logic [4:0] rd, input logic [31:0] d,
                         input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad);
        is_write_in = we; rd_in = rd; wb_data_in = d;
        rs1_addr = a1; rs2_addr = a2; dbg_addr = ad;
        #2;
        check("rs1_data", rs1_data, read_exp(a1));
        check("rs2_data", rs2_data, read_exp(a2));
        check("dbg_data", dbg_data, mem[ad]);
        @(posedge clk); #1;
        if (we && rd != 5'd0) begin
            mem[rd] = d;
            cnt = (cnt + 1) % 65536;
            last = rd;
        end
        check("write_count", {16'd0, write_count}, cnt[31:0]);
        check("last_rd", {27'd0, last_rd}, {27'd0, last});
    endtask

    initial begin
        reset = 1'b1; is_write_in = 1'b0; rd_in = '0; wb_data_in = '0;
        rs1_addr = '0; rs2_addr = '0; dbg_addr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        // Post-reset sweep of every index on all three read ports
        for (int i = 0; i < 32; i++) apply(1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i), 5'(i));
        // Write x5 then read it back
        apply(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 5'd0);
        apply(1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 5'd5);
        check("x5_dbg_direct", dbg_data, 32'hDEADBEEF);
        // Bypass of x7 while the committed value is still zero
        apply(1'b1, 5'd7, 32'h12345678, 5'd5, 5'd7, 5'd7);
        apply(1'b0, 5'd0, 32'd0, 5'd7, 5'd7, 5'd7);
        // Writes to x0 are dropped and never bypassed
        apply(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
        apply(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        // Back-to-back writes to x3, both ports aimed at it
        apply(1'b1, 5'd3, 32'd1, 5'd3, 5'd3, 5'd3);
        apply(1'b1, 5'd3, 32'd2, 5'd3, 5'd3, 5'd3);
        apply(1'b0, 5'd0, 32'd0, 5'd3, 5'd3, 5'd3);
        check("x3_final", dbg_data, 32'd2);
        // Randomized traffic, biased toward address collisions
        for (int n = 0; n < 400; n++) begin
            logic [4:0] rd;
            rd = 5'($urandom_range(0, 7));
            apply(1'($urandom), rd, $urandom,
                  ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 7)),
                  ($urandom_range(0, 2) == 0) ? rd : 5'($urandom),
                  5'($urandom_range(0, 7)));
        end
        // Async reset between edges discards an in-flight write to x9
        apply(1'b1, 5'd9, 32'hA5A5A5A5, 5'd0, 5'd0, 5'd0);
        is_write_in = 1'b1; rd_in = 5'd9; wb_data_in = 32'h55AA55AA;
        rs1_addr = 5'd9; rs2_addr = 5'd9; dbg_addr = 5'd9;
        #2;
        check("x9_bypass_pre_reset", rs1_data, 32'h55AA55AA);
        check("x9_dbg_pre_reset", dbg_data, 32'hA5A5A5A5);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("rs1_in_reset", rs1_data, 32'd0);
        check("rs2_in_reset", rs2_data, 32'd0);
        check("dbg_in_reset", dbg_data, 32'd0);
        check("count_in_reset", {16'd0, write_count}, 32'd0);
        check("last_rd_in_reset", {27'd0, last_rd}, 32'd0);
        @(posedge clk); #1;
        check("rs1_reset_across_edge", rs1_data, 32'd0);
        reset = 1'b0;
        apply(1'b0, 5'd0, 32'd0, 5'd9, 5'd9, 5'd9);
        apply(1'b1, 5'd9, 32'h0BADF00D, 5'd9, 5'd1, 5'd9);
        apply(1'b0, 5'd0, 32'd0, 5'd9, 5'd9, 5'd9);
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
